// File: rtl/rdma_cmd_sequencer_pkg.sv
// rtl/rdma_cmd_sequencer_pkg.sv - shared states, default widths and sizing helper for the 2-D read-DMA sequencer
package rdma_cmd_sequencer_pkg;

    localparam int DEF_ADDRESS_BITS    = 32;
    localparam int DEF_LENGTH_BITS     = 32;
    localparam int DEF_COUNT_BITS      = 16;
    localparam int DEF_MAX_OUTSTANDING = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_NULL  = 2'd3
    } seq_state_e;

    function automatic int outstanding_bits(input int max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

endpackage

// File: rtl/rdma_cmd_sequencer_if.sv
// rtl/rdma_cmd_sequencer_if.sv - job, DMA command and DMA output-stream tap signals of the sequencer
interface rdma_cmd_sequencer_if
    import rdma_cmd_sequencer_pkg::*;
#(
    parameter int ADDRESS_BITS = DEF_ADDRESS_BITS,
    parameter int LENGTH_BITS  = DEF_LENGTH_BITS,
    parameter int COUNT_BITS   = DEF_COUNT_BITS
);
    logic [ADDRESS_BITS-1:0] job_address;
    logic [LENGTH_BITS-1:0]  job_bytes;
    logic [ADDRESS_BITS-1:0] job_stride;
    logic [COUNT_BITS-1:0]   job_lines;
    logic                    job_valid;
    logic                    job_ready;

    logic [ADDRESS_BITS-1:0] cmd_address;
    logic [LENGTH_BITS-1:0]  cmd_bytes;
    logic                    cmd_valid;
    logic                    cmd_ready;

    logic                    mon_tvalid;
    logic                    mon_tready;
    logic                    mon_tlast;

    modport master (
        output job_address, job_bytes, job_stride, job_lines, job_valid,
        input  job_ready,
        input  cmd_address, cmd_bytes, cmd_valid,
        output cmd_ready,
        output mon_tvalid, mon_tready, mon_tlast
    );

    modport slave (
        input  job_address, job_bytes, job_stride, job_lines, job_valid,
        output job_ready,
        output cmd_address, cmd_bytes, cmd_valid,
        input  cmd_ready,
        input  mon_tvalid, mon_tready, mon_tlast
    );

endinterface

// File: rtl/rdma_outstanding_cnt.sv
// rtl/rdma_outstanding_cnt.sv - saturating up/down count of DMA commands issued but not yet completed
module rdma_outstanding_cnt
    import rdma_cmd_sequencer_pkg::*;
#(
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int CNT_BITS        = outstanding_bits(MAX_OUTSTANDING)
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                inc_i,
    input  logic                dec_i,
    output logic [CNT_BITS-1:0] count_o,
    output logic                full_o,
    output logic                empty_o
);

    localparam logic [CNT_BITS-1:0] MAX_V = CNT_BITS'(MAX_OUTSTANDING);

    logic [CNT_BITS-1:0] count_q;
    logic [CNT_BITS-1:0] count_d;

    // Simultaneous inc and dec cancel; each direction saturates independently.
    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i && !full_o) begin
            count_d = count_q + CNT_BITS'(1);
        end else if (dec_i && !inc_i && !empty_o) begin
            count_d = count_q - CNT_BITS'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign full_o  = (count_q == MAX_V);
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/rdma_cmd_sequencer.sv
// rtl/rdma_cmd_sequencer.sv - issues one DMA read command per line of a 2-D job and reports completion via TLAST
module rdma_cmd_sequencer
    import rdma_cmd_sequencer_pkg::*;
#(
    parameter int ADDRESS_BITS    = DEF_ADDRESS_BITS,
    parameter int LENGTH_BITS     = DEF_LENGTH_BITS,
    parameter int COUNT_BITS      = DEF_COUNT_BITS,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    rdma_cmd_sequencer_if.slave   bus,
    output logic                  busy,
    output logic                  done,
    output logic [COUNT_BITS-1:0] lines_done
);

    localparam int OB  = outstanding_bits(MAX_OUTSTANDING);
    localparam int OBW = OB + 1;
    localparam logic [OBW-1:0] MAX_V = OBW'(MAX_OUTSTANDING);

    seq_state_e              state_q, state_d;
    logic [ADDRESS_BITS-1:0] addr_q, addr_d;
    logic [LENGTH_BITS-1:0]  bytes_q, bytes_d;
    logic [ADDRESS_BITS-1:0] stride_q, stride_d;
    logic [COUNT_BITS-1:0]   lines_q, lines_d;
    logic [COUNT_BITS-1:0]   issued_q, issued_d;
    logic [COUNT_BITS-1:0]   lines_done_q, lines_done_d;
    logic                    cmd_valid_q, cmd_valid_d;
    logic                    job_ready_q, job_ready_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic          hs;
    logic          beat;
    logic          cpl;
    logic          cnt_inc;
    logic          cnt_full;
    logic          cnt_empty;
    logic [OB-1:0] cnt;
    logic [OBW-1:0] cnt_nxt;
    logic          room;
    logic          accept;

    rdma_outstanding_cnt #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_BITS        (OB)
    ) u_cnt (
        .aclk    (aclk),
        .aresetn (aresetn),
        .inc_i   (cnt_inc),
        .dec_i   (cpl),
        .count_o (cnt),
        .full_o  (cnt_full),
        .empty_o (cnt_empty)
    );

    // A completion beat only counts against something actually outstanding.
    assign hs      = cmd_valid_q && bus.cmd_ready;
    assign beat    = bus.mon_tvalid && bus.mon_tready && bus.mon_tlast;
    assign cpl     = beat && !cnt_empty;
    assign cnt_inc = hs && !cnt_full;
    assign cnt_nxt = {1'b0, cnt} + OBW'(cnt_inc) - OBW'(cpl);
    assign room    = (cnt_nxt < MAX_V);
    assign accept  = bus.job_valid && job_ready_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        bytes_d      = bytes_q;
        stride_d     = stride_q;
        lines_d      = lines_q;
        issued_d     = issued_q;
        cmd_valid_d  = cmd_valid_q;
        done_d       = 1'b0;
        lines_done_d = (cpl && busy_q) ? lines_done_q + COUNT_BITS'(1) : lines_done_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d       = bus.job_address;
                    bytes_d      = bus.job_bytes;
                    stride_d     = bus.job_stride;
                    lines_d      = bus.job_lines;
                    issued_d     = '0;
                    lines_done_d = '0;
                    if (bus.job_lines == '0 || bus.job_bytes == '0) begin
                        state_d = S_NULL;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_NULL: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            S_ISSUE: begin
                if (hs) begin
                    addr_d   = addr_q + stride_q;
                    issued_d = issued_q + COUNT_BITS'(1);
                    if (issued_q == lines_q - COUNT_BITS'(1)) begin
                        state_d     = S_DRAIN;
                        cmd_valid_d = 1'b0;
                    end else begin
                        cmd_valid_d = room;
                    end
                end else if (!cmd_valid_q) begin
                    cmd_valid_d = room;
                end
            end
            S_DRAIN: begin
                if (cnt_nxt == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        job_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE) || done_d;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            bytes_q      <= '0;
            stride_q     <= '0;
            lines_q      <= '0;
            issued_q     <= '0;
            lines_done_q <= '0;
            cmd_valid_q  <= 1'b0;
            job_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            bytes_q      <= bytes_d;
            stride_q     <= stride_d;
            lines_q      <= lines_d;
            issued_q     <= issued_d;
            lines_done_q <= lines_done_d;
            cmd_valid_q  <= cmd_valid_d;
            job_ready_q  <= job_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.job_ready   = job_ready_q;
    assign bus.cmd_address = addr_q;
    assign bus.cmd_bytes   = bytes_q;
    assign bus.cmd_valid   = cmd_valid_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign lines_done      = lines_done_q;

endmodule

// File: tb/tb_rdma_cmd_sequencer.sv
// tb/tb_rdma_cmd_sequencer.sv - scoreboard bench for rdma_cmd_sequencer with a simple DMA engine model
module tb_rdma_cmd_sequencer;

    localparam int AW = 32;
    localparam int LW = 32;
    localparam int CW = 16;
    localparam int MO = 2;

    logic          aclk    = 1'b0;
    logic          aresetn = 1'b0;
    logic          busy;
    logic          done;
    logic [CW-1:0] lines_done;

    always #5 aclk = ~aclk;

    rdma_cmd_sequencer_if #(.ADDRESS_BITS(AW), .LENGTH_BITS(LW), .COUNT_BITS(CW)) bus ();

    rdma_cmd_sequencer #(
        .ADDRESS_BITS    (AW),
        .LENGTH_BITS     (LW),
        .COUNT_BITS      (CW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .bus        (bus.slave),
        .busy       (busy),
        .done       (done),
        .lines_done (lines_done)
    );

    int checks   = 0;
    int failures = 0;

    logic [AW+LW-1:0] exp_cmd_q[$];
    int               exp_done_q[$];
    int               due_q[$];

    int cyc             = 0;
    int tl_delay        = 2;
    int ahead           = 0;
    int max_ahead       = 0;
    int lines_model     = 0;
    int hs_in_job       = 0;
    int stall_left      = 0;
    int done_seen       = 0;
    bit one_at_a_time   = 1'b1;
    bit force_beat      = 1'b0;
    bit same_cycle_seen = 1'b0;
    bit hold_prev       = 1'b0;
    logic [AW-1:0] hold_addr;
    logic [LW-1:0] hold_bytes;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // DMA engine model and scoreboard: observes outputs, then drives inputs for the next edge.
    initial begin : monitor
        logic hs, beat, beat_eff, acc;
        logic [AW+LW-1:0] exp;
        bus.cmd_ready  = 1'b0;
        bus.mon_tvalid = 1'b0;
        bus.mon_tready = 1'b0;
        bus.mon_tlast  = 1'b0;
        @(posedge aclk);
        forever begin
            @(negedge aclk);
            cyc++;
            check_eq("outstanding", 64'(dut.u_cnt.count_o), 64'(ahead));
            check_eq("lines_done", 64'(lines_done), 64'(lines_model));
            if (hold_prev) begin
                check_eq("hold_valid", 64'(bus.cmd_valid), 64'(1));
                check_eq("hold_address", 64'(bus.cmd_address), 64'(hold_addr));
                check_eq("hold_bytes", 64'(bus.cmd_bytes), 64'(hold_bytes));
            end
            if (done === 1'b1) begin
                check_eq("done_expected", 64'(exp_done_q.size() > 0), 64'(1));
                if (exp_done_q.size() > 0) begin
                    check_eq("done_lines", 64'(lines_done), 64'(exp_done_q.pop_front()));
                end
                check_eq("busy_at_done", 64'(busy), 64'(1));
                done_seen++;
            end

            bus.cmd_ready = one_at_a_time ? (ahead == 0 && due_q.size() == 0) : 1'b1;
            if (stall_left > 0 && hs_in_job == 1 && bus.cmd_valid === 1'b1) begin
                bus.cmd_ready = 1'b0;
                stall_left--;
            end
            beat = force_beat || (due_q.size() > 0 && due_q[0] <= cyc);
            if (!force_beat && beat) begin
                void'(due_q.pop_front());
            end
            force_beat     = 1'b0;
            bus.mon_tvalid = beat || (cyc % 3 == 0);
            bus.mon_tready = beat || (cyc % 4 == 1);
            bus.mon_tlast  = beat || (cyc % 2 == 0);

            hs       = bus.cmd_valid && bus.cmd_ready;
            acc      = bus.job_valid && bus.job_ready;
            beat_eff = beat && (ahead > 0);
            if (!aresetn) begin
                ahead       = 0;
                lines_model = 0;
                hs_in_job   = 0;
                hold_prev   = 1'b0;
                due_q.delete();
            end else begin
                if (hs) begin
                    check_eq("cmd_expected", 64'(exp_cmd_q.size() > 0), 64'(1));
                    if (exp_cmd_q.size() > 0) begin
                        exp = exp_cmd_q.pop_front();
                        check_eq("cmd_address", 64'(bus.cmd_address), 64'(exp[AW+LW-1:LW]));
                        check_eq("cmd_bytes", 64'(bus.cmd_bytes), 64'(exp[LW-1:0]));
                    end
                    due_q.push_back(cyc + tl_delay);
                    hs_in_job++;
                end
                if (hs && beat_eff) same_cycle_seen = 1'b1;
                if (hs) ahead++;
                if (beat_eff) ahead--;
                if (ahead > max_ahead) max_ahead = ahead;
                if (hs) check_eq("outstanding_limit", 64'(ahead <= MO), 64'(1));
                if (acc) begin
                    lines_model = 0;
                    hs_in_job   = 0;
                end else if (beat_eff) begin
                    lines_model++;
                end
                hold_prev  = bus.cmd_valid && !bus.cmd_ready;
                hold_addr  = bus.cmd_address;
                hold_bytes = bus.cmd_bytes;
            end
        end
    end

    task automatic drive_job(input logic [AW-1:0] a, input logic [LW-1:0] b,
                             input logic [AW-1:0] s, input logic [CW-1:0] n);
        int w;
        w = 0;
        while (bus.job_ready !== 1'b1 && w < 200) begin
            @(posedge aclk); #2;
            w++;
        end
        check_eq("job_ready_before_job", 64'(bus.job_ready), 64'(1));
        if (n != 0 && b != 0) begin
            for (int i = 0; i < int'(n); i++) begin
                exp_cmd_q.push_back({a + AW'(i) * s, b});
            end
            exp_done_q.push_back(int'(n));
        end else begin
            exp_done_q.push_back(0);
        end
        bus.job_address = a;
        bus.job_bytes   = b;
        bus.job_stride  = s;
        bus.job_lines   = n;
        bus.job_valid   = 1'b1;
        @(posedge aclk); #2;
        bus.job_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int w;
        w = 0;
        while (done !== 1'b1 && w < budget) begin
            @(posedge aclk); #2;
            w++;
        end
        check_eq(tag, 64'(done), 64'(1));
        if (done === 1'b1) begin
            check_eq("job_ready_at_done", 64'(bus.job_ready), 64'(1));
            @(posedge aclk); #2;
            check_eq("done_single_pulse", 64'(done), 64'(0));
            check_eq("busy_after_done", 64'(busy), 64'(0));
        end
    endtask

    task automatic null_job(input string tag, input logic [LW-1:0] b, input logic [CW-1:0] n);
        drive_job(32'h0000_3000, b, 32'h10, n);
        check_eq({tag, "_busy"}, 64'(busy), 64'(1));
        check_eq({tag, "_done_early"}, 64'(done), 64'(0));
        check_eq({tag, "_no_cmd_a"}, 64'(bus.cmd_valid), 64'(0));
        @(posedge aclk); #2;
        check_eq({tag, "_done"}, 64'(done), 64'(1));
        check_eq({tag, "_lines_done"}, 64'(lines_done), 64'(0));
        check_eq({tag, "_no_cmd_b"}, 64'(bus.cmd_valid), 64'(0));
        @(posedge aclk); #2;
        check_eq({tag, "_done_drop"}, 64'(done), 64'(0));
        check_eq({tag, "_idle"}, 64'(busy), 64'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_job_ready"}, 64'(bus.job_ready), 64'(1));
        check_eq({tag, "_cmd_valid"}, 64'(bus.cmd_valid), 64'(0));
        check_eq({tag, "_cmd_address"}, 64'(bus.cmd_address), 64'(0));
        check_eq({tag, "_cmd_bytes"}, 64'(bus.cmd_bytes), 64'(0));
        check_eq({tag, "_busy"}, 64'(busy), 64'(0));
        check_eq({tag, "_done"}, 64'(done), 64'(0));
        check_eq({tag, "_lines_done"}, 64'(lines_done), 64'(0));
    endtask

    initial begin : main
        int w;
        int done_before;
        bus.job_address = '0;
        bus.job_bytes   = '0;
        bus.job_stride  = '0;
        bus.job_lines   = '0;
        bus.job_valid   = 1'b0;
        repeat (3) @(posedge aclk);
        #2;
        check_reset_outputs("reset");
        aresetn = 1'b1;
        @(posedge aclk); #2;

        one_at_a_time = 1'b1;
        tl_delay      = 3;
        drive_job(32'h0000_1000, 32'd64, 32'h100, 16'd4);
        check_eq("t1_latency_idle", 64'(bus.cmd_valid), 64'(0));
        @(posedge aclk); #2;
        check_eq("t1_latency_valid", 64'(bus.cmd_valid), 64'(1));
        check_eq("t1_first_address", 64'(bus.cmd_address), 64'h1000);
        wait_done("t1_done", 300);
        check_eq("t1_lines_hold", 64'(lines_done), 64'(4));

        null_job("t2_bytes0", 32'd0, 16'd5);
        null_job("t2_lines0", 32'd32, 16'd0);

        one_at_a_time   = 1'b0;
        tl_delay        = 20;
        max_ahead       = 0;
        same_cycle_seen = 1'b0;
        drive_job(32'h0000_4000, 32'd128, 32'h80, 16'd6);
        wait_done("t3_done", 600);
        check_eq("t3_max_ahead", 64'(max_ahead), 64'(MO));
        check_eq("t3_same_cycle", 64'(same_cycle_seen), 64'(1));

        one_at_a_time = 1'b1;
        tl_delay      = 2;
        drive_job(32'hFFFF_FF80, 32'd16, 32'h40, 16'd3);
        wait_done("t4_done", 300);

        one_at_a_time = 1'b0;
        tl_delay      = 4;
        stall_left    = 10;
        drive_job(32'h0000_5000, 32'd256, 32'h1000, 16'd3);
        w = 0;
        while (!(hs_in_job == 1 && bus.cmd_valid === 1'b1) && w < 50) begin
            @(posedge aclk); #2;
            w++;
        end
        check_eq("t5_stall_reached", 64'(bus.cmd_address), 64'h6000);
        @(posedge aclk); #2;
        check_eq("t5_job_ready_busy", 64'(bus.job_ready), 64'(0));
        bus.job_address = 32'h0009_0000;
        bus.job_bytes   = 32'd8;
        bus.job_stride  = 32'h8;
        bus.job_lines   = 16'd2;
        bus.job_valid   = 1'b1;
        @(posedge aclk); #2;
        bus.job_valid = 1'b0;
        repeat (4) @(posedge aclk);
        #2;
        check_eq("t5_still_stalled", 64'(bus.cmd_address), 64'h6000);
        wait_done("t5_done", 300);
        force_beat = 1'b1;
        repeat (3) @(posedge aclk);
        #2;
        check_eq("t5_spurious_outstanding", 64'(dut.u_cnt.count_o), 64'(0));
        check_eq("t5_spurious_lines", 64'(lines_done), 64'(3));
        check_eq("t5_spurious_busy", 64'(busy), 64'(0));

        tl_delay = 30;
        drive_job(32'h0000_7000, 32'd8, 32'h8, 16'd2);
        w = 0;
        while (exp_cmd_q.size() > 0 && w < 100) begin
            @(posedge aclk); #2;
            w++;
        end
        repeat (3) @(posedge aclk);
        #2;
        check_eq("t6_draining", 64'(busy), 64'(1));
        exp_done_q.delete();
        done_before = done_seen;
        aresetn = 1'b0;
        @(posedge aclk); #2;
        check_reset_outputs("t6_reset");
        aresetn = 1'b1;
        repeat (40) @(posedge aclk);
        #2;
        check_eq("t6_no_done", 64'(done_seen), 64'(done_before));
        tl_delay = 2;
        drive_job(32'h0000_8000, 32'd4, 32'h4, 16'd3);
        wait_done("t6_rerun_done", 300);

        check_eq("cmd_queue_empty", 64'(exp_cmd_q.size()), 64'(0));
        check_eq("done_queue_empty", 64'(exp_done_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
